// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch stage, the instruction ROM, ID-stage redirect/hazard
// control and the IF/ID pipeline register outputs.
interface if_fetch_unit_if #(
   parameter int IM_ADDR_W = 10
);
   logic                 stall;
   logic                 flush;
   logic [1:0]           npc_sel;
   logic                 br_taken;
   logic [15:0]          br_imm;
   logic [25:0]          j_index;
   logic [31:0]          jr_target;
   logic [IM_ADDR_W-1:0] im_addr;
   logic [31:0]          im_instr;
   logic [31:0]          pc;
   logic [31:0]          id_instr;
   logic [31:0]          id_pc;
   logic [31:0]          id_pc8;
   logic                 id_valid;
   logic                 fetch_err;

   modport master (
      output stall, flush, npc_sel, br_taken, br_imm, j_index, jr_target, im_instr,
      input  im_addr, pc, id_instr, id_pc, id_pc8, id_valid, fetch_err
   );

   modport slave (
      input  stall, flush, npc_sel, br_taken, br_imm, j_index, jr_target, im_instr,
      output im_addr, pc, id_instr, id_pc, id_pc8, id_valid, fetch_err
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, ROM addressing, IF/ID register,
// delayed-branch redirects, stall/flush handling and halt on illegal fetch.
//
// state   | meaning
// ST_RUN  | normal fetching
// ST_HALT | illegal fetch address seen; pc frozen, bubbles only, until reset
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int          IM_ADDR_W = 10
) (
   input logic            clk,
   input logic            reset,
   if_fetch_unit_if.slave bus
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [32:0] PC_END = {1'b0, RESET_PC} + (33'd4 << IM_ADDR_W);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        id_valid_q, id_valid_d;
   logic        fetch_err_q, fetch_err_d;

   logic        illegal;
   logic [31:0] base;
   logic [31:0] br_off;
   logic [31:0] npc;

   assign illegal = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || ({1'b0, pc_q} >= PC_END);
   assign base    = id_pc_q + 32'd4;
   assign br_off  = {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};

   // RESET_PC is word aligned, so the offset subtraction never borrows out of bits [1:0]
   assign bus.im_addr   = pc_q[IM_ADDR_W+1:2] - RESET_PC[IM_ADDR_W+1:2];
   assign bus.pc        = pc_q;
   assign bus.id_instr  = id_instr_q;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_pc8    = id_pc_q + 32'd8;
   assign bus.id_valid  = id_valid_q;
   assign bus.fetch_err = fetch_err_q;

   always_comb begin
      npc = pc_q + 32'd4;
      if (id_valid_q) begin
         unique case (bus.npc_sel)
            2'b01:   if (bus.br_taken) npc = base + br_off;
            2'b10:   npc = {base[31:28], bus.j_index, 2'b00};
            2'b11:   npc = bus.jr_target;
            default: npc = pc_q + 32'd4;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      id_instr_d  = id_instr_q;
      id_pc_d     = id_pc_q;
      id_valid_d  = id_valid_q;
      fetch_err_d = fetch_err_q;
      unique case (state_q)
         ST_RUN: begin
            if (!bus.stall) begin
               if (illegal) begin
                  id_instr_d  = '0;
                  id_valid_d  = 1'b0;
                  id_pc_d     = pc_q;
                  fetch_err_d = 1'b1;
                  state_d     = ST_HALT;
               end else if (bus.flush) begin
                  pc_d       = npc;
                  id_instr_d = '0;
                  id_valid_d = 1'b0;
                  id_pc_d    = pc_q;
               end else begin
                  pc_d       = npc;
                  id_instr_d = bus.im_instr;
                  id_valid_d = 1'b1;
                  id_pc_d    = pc_q;
               end
            end
         end
         ST_HALT: begin
            id_instr_d  = '0;
            id_valid_d  = 1'b0;
            id_pc_d     = pc_q;
            fetch_err_d = 1'b1;
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         id_instr_q  <= '0;
         id_pc_q     <= RESET_PC;
         id_valid_q  <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         id_instr_q  <= id_instr_d;
         id_pc_q     <= id_pc_d;
         id_valid_q  <= id_valid_d;
         fetch_err_q <= fetch_err_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and random checks of the fetch stage against a behavioural model.
module tb_if_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_3000;
   localparam int          IMW = 10;
   localparam int          NW  = 1 << IMW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   if_fetch_unit_if #(.IM_ADDR_W(IMW)) bus ();
   logic [31:0] rom [NW];
   assign bus.im_instr = rom[bus.im_addr];

   if_fetch_unit #(.RESET_PC(RPC), .IM_ADDR_W(IMW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] m_pc, m_iinstr, m_ipc;
   logic        m_ivalid, m_err, m_halt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] p);
      return (p[1:0] == 2'b00) && (p >= RPC) && ({1'b0, p} < ({1'b0, RPC} + 33'(4 * NW)));
   endfunction

   task automatic check_all();
      logic [31:0] off;
      off = m_pc - RPC;
      check("pc",        bus.pc,              m_pc);
      check("id_instr",  bus.id_instr,        m_iinstr);
      check("id_pc",     bus.id_pc,           m_ipc);
      check("id_pc8",    bus.id_pc8,          m_ipc + 32'd8);
      check("id_valid",  32'(bus.id_valid),   32'(m_ivalid));
      check("fetch_err", 32'(bus.fetch_err),  32'(m_err));
      check("im_addr",   32'(bus.im_addr),    (off >> 2) & 32'(NW - 1));
   endtask

   task automatic set_in(input logic st, input logic fl, input logic [1:0] sel, input logic tk,
                         input logic [15:0] imm, input logic [25:0] ji, input logic [31:0] jr);
      bus.stall = st; bus.flush = fl; bus.npc_sel = sel; bus.br_taken = tk;
      bus.br_imm = imm; bus.j_index = ji; bus.jr_target = jr;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
   endtask

   // One rising edge; model next state is computed from the pre-edge view.
   task automatic tick();
      logic [31:0] npc, b4, off;
      logic [31:0] n_pc, n_ii, n_ip;
      logic        n_iv, n_err, n_halt;
      b4  = m_ipc + 32'd4;
      npc = m_pc + 32'd4;
      if (m_ivalid) begin
         case (bus.npc_sel)
            2'd1: if (bus.br_taken) npc = b4 + 32'(int'($signed(bus.br_imm)) * 4);
            2'd2: npc = {b4[31:28], bus.j_index, 2'b00};
            2'd3: npc = bus.jr_target;
            default: ;
         endcase
      end
      n_pc = m_pc; n_ii = m_iinstr; n_ip = m_ipc; n_iv = m_ivalid; n_err = m_err; n_halt = m_halt;
      if (m_halt) begin
         n_ii = 0; n_iv = 0; n_ip = m_pc; n_err = 1;
      end else if (bus.stall) begin
      end else if (!legal(m_pc)) begin
         n_ii = 0; n_iv = 0; n_ip = m_pc; n_err = 1; n_halt = 1;
      end else if (bus.flush) begin
         n_ii = 0; n_iv = 0; n_ip = m_pc; n_pc = npc;
      end else begin
         off  = (m_pc - RPC) >> 2;
         n_ii = rom[off[IMW-1:0]]; n_iv = 1; n_ip = m_pc; n_pc = npc;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_iinstr = n_ii; m_ipc = n_ip; m_ivalid = n_iv; m_err = n_err; m_halt = n_halt;
      check_all();
      @(negedge clk);
   endtask

   // Called at a falling edge: reset is asserted between edges and checked without a clock.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      m_pc = RPC; m_iinstr = 0; m_ipc = RPC; m_ivalid = 0; m_err = 0; m_halt = 0;
      check_all();
      check("rst_pc",  bus.pc, 32'h0000_3000);
      check("rst_err", 32'(bus.fetch_err), 32'd0);
      @(negedge clk);
      idle();
      reset = 1'b1;
   endtask

   initial begin
      int halt_cnt;
      logic [31:0] jr;
      reset = 1'b0;
      idle();
      for (int i = 0; i < NW; i++) rom[i] = (32'(i) << 20) ^ ($urandom & 32'h000F_FFFF);
      @(negedge clk);

      // sequential fetch after reset
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("seq_pc",    bus.pc,    RPC + 32'(4 * k));
         check("seq_id_pc", bus.id_pc, RPC + 32'(4 * (k - 1)));
         check("seq_valid", 32'(bus.id_valid), 32'd1);
      end

      // taken branch with delay slot
      do_reset();
      repeat (3) tick();
      set_in(1'b0, 1'b0, 2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0);
      tick();
      check("beq_slot", bus.id_pc, 32'h0000_300C);
      check("beq_pc",   bus.pc,    32'h0000_3004);
      idle();
      tick();
      check("beq_after", bus.id_pc, 32'h0000_3004);

      // not-taken branch
      do_reset();
      repeat (3) tick();
      set_in(1'b0, 1'b0, 2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0);
      tick();
      check("bnt_pc", bus.pc, 32'h0000_3010);

      // jump then jr
      do_reset();
      tick();
      set_in(1'b0, 1'b0, 2'b10, 1'b0, 16'h0, 26'h0000C10, 32'h0);
      tick();
      check("j_slot", bus.id_pc, 32'h0000_3004);
      check("j_pc",   bus.pc,    32'h0000_3040);
      set_in(1'b0, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3100);
      tick();
      check("jr_pc", bus.pc, 32'h0000_3100);
      idle();
      tick();
      check("jr_id_pc", bus.id_pc, 32'h0000_3100);

      // stall holds a pending redirect
      do_reset();
      repeat (3) tick();
      set_in(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0);
      repeat (3) begin
         tick();
         check("stall_pc",    bus.pc,    32'h0000_300C);
         check("stall_id_pc", bus.id_pc, 32'h0000_3008);
      end
      bus.stall = 1'b0;
      tick();
      check("stall_rel_pc", bus.pc, 32'h0000_3004);
      set_in(1'b1, 1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
      tick();
      check("stfl_pc",    bus.pc, 32'h0000_3004);
      check("stfl_valid", 32'(bus.id_valid), 32'd1);
      bus.stall = 1'b0;
      tick();
      check("flush_valid", 32'(bus.id_valid), 32'd0);
      check("flush_pc",    bus.pc, 32'h0000_3008);

      // unaligned jr target halts
      do_reset();
      tick();
      set_in(1'b0, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
      tick();
      idle();
      tick();
      check("ua_err",   32'(bus.fetch_err), 32'd1);
      check("ua_valid", 32'(bus.id_valid),  32'd0);
      check("ua_pc",    bus.pc, 32'h0000_3002);
      tick();
      check("ua_frozen", bus.pc, 32'h0000_3002);

      // running off the top of the ROM halts
      do_reset();
      tick();
      set_in(1'b0, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, RPC + 32'(4 * (NW - 2)));
      tick();
      idle();
      tick();
      tick();
      check("top_last_err",   32'(bus.fetch_err), 32'd0);
      check("top_last_id_pc", bus.id_pc, 32'h0000_3FFC);
      tick();
      check("top_err", 32'(bus.fetch_err), 32'd1);
      check("top_pc",  bus.pc, 32'h0000_4000);

      // mid-stream reset, then redirect ignored while id_valid=0
      do_reset();
      repeat (2) tick();
      do_reset();
      set_in(1'b0, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3100);
      tick();
      check("inv_sel_pc", bus.pc, 32'h0000_3004);
      idle();
      tick();

      // random stimulus against the model
      halt_cnt = 0;
      for (int it = 0; it < 600; it++) begin
         if ((m_halt && halt_cnt > 3) || ($urandom % 64 == 0)) begin
            do_reset();
            halt_cnt = 0;
         end else begin
            jr = RPC + 32'(4 * $urandom_range(0, NW - 1));
            if ($urandom % 16 == 0) jr = jr + 32'd2;
            if ($urandom % 32 == 0) jr = $urandom;
            set_in(($urandom % 5) == 0, ($urandom % 8) == 0, 2'($urandom), 1'($urandom),
                   16'($urandom_range(0, 64)) - 16'd32,
                   26'((RPC >> 2) + 32'($urandom_range(0, NW - 1))), jr);
            tick();
            if (m_halt) halt_cnt++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
